// File: rtl/blend_pkg.sv
// Shared definitions for the alpha-blend multiplier scheduler: FSM state
// encoding, blend constants and the rounding/saturation helper.
package blend_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MUL_A = 3'd2,
    S_MUL_B = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0]  ALPHA_MAX = 8'd255;
  localparam logic [16:0] RND_OFS   = 17'd128;

  // Round the 17-bit weighted sum to an 8-bit pixel, saturating at 255.
  // The +128 is done one bit wider so that a worst-case overshoot from an
  // approximate multiplier (sum near 2^17) saturates instead of wrapping.
  function automatic logic [7:0] blend_round(input logic [16:0] sum17);
    logic [17:0] rnd;
    rnd = {1'b0, sum17} + {1'b0, RND_OFS};
    return (rnd[17:16] != 2'b00) ? ALPHA_MAX : rnd[15:8];
  endfunction

endpackage

// File: rtl/blend_mult_sched.sv
// blend_mult_sched: walks a frame of pixel pairs through one shared external
// 8x8 multiplier, producing out = round((a*alpha + b*(255-alpha)) / 256).
// Four cycles per pixel: READ, MUL_A, MUL_B, OUT (OUT stalls on out_ready).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort, alpha frame control; alpha sampled on an accepted start
//   busy, done          frame status; done is a one-cycle pulse
//   rd_en, rd_addr      pixel memory read; rd_pix_a/rd_pix_b valid next cycle
//   mul_a, mul_b, mul_r external multiplier (mul_r combinational)
//   out_valid/out_ready result handshake with out_pix, out_addr
module blend_mult_sched
  import blend_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int NUM_PIX = 262144
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        alpha,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_pix_a,
  input  logic [7:0]        rd_pix_b,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_pix,
  output logic [ADDR_W-1:0] out_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        alpha_q;
  logic [7:0]        pix_b_q;
  logic [15:0]       p1_q;
  logic [16:0]       sum_q;
  logic              last;
  logic              accept_start;

  assign last         = (addr_q == LAST_ADDR);
  assign accept_start = (state_q == S_IDLE) && start && !abort;

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    mul_a     = '0;
    mul_b     = '0;
    out_valid = 1'b0;
    out_pix   = '0;
    out_addr  = '0;
    case (state_q)
      S_IDLE: if (accept_start) state_d = S_READ;
      S_READ: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = addr_q;
        state_d = S_MUL_A;
      end
      S_MUL_A: begin
        busy    = 1'b1;
        mul_a   = rd_pix_a;
        mul_b   = alpha_q;
        state_d = S_MUL_B;
      end
      S_MUL_B: begin
        busy    = 1'b1;
        mul_a   = pix_b_q;
        mul_b   = ALPHA_MAX - alpha_q;
        state_d = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_addr  = addr_q;
        out_pix   = blend_round(sum_q);
        if (out_ready) state_d = last ? S_DONE : S_READ;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // abort wins over everything, including the OUT handshake
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      alpha_q <= '0;
      pix_b_q <= '0;
      p1_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        alpha_q <= alpha;
        addr_q  <= '0;
      end
      if (state_q == S_MUL_A) begin
        pix_b_q <= rd_pix_b;
        p1_q    <= mul_r;
      end
      if (state_q == S_MUL_B) sum_q <= {1'b0, p1_q} + {1'b0, mul_r};
      // counter stops at the last pixel; an aborted pixel is not advanced past
      if (state_q == S_OUT && out_ready && !abort && !last) addr_q <= addr_q + 1'b1;
    end
  end

endmodule
